// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter
// Four-way round-robin arbiter for one shared resource. The registered 2-bit
// grant index is shadowed by a registered one-hot decode, so both views change
// on the same edge and always agree.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   req[3:0]   in   level request per agent, held until served
//   done       in   current owner finished (ignored while gnt_valid=0)
//   gnt_idx    out  encoded owner index, 0 when no grant
//   gnt[3:0]   out  one-hot decode of gnt_idx, 0 when no grant
//   gnt_valid  out  a grant is active this cycle
//   timeout    out  one-cycle pulse after a grant is revoked by the hold limit
module rr_decoder_arbiter #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] gnt_idx,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q;
    logic [1:0]       gnt_idx_q;
    logic [3:0]       gnt_q;
    logic             gnt_valid_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       last_q;

    logic             pick_found;
    logic [1:0]       pick_idx;
    logic [1:0]       cand;
    logic             release_now;

    // Search starts just after the last served agent; 2-bit addition wraps.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign release_now = done || !req[gnt_idx_q] || (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_idx_q   <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
            last_q      <= 2'd3;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE, GAP: begin
                    if (pick_found) begin
                        state_q     <= BUSY;
                        gnt_idx_q   <= pick_idx;
                        gnt_q       <= 4'b0001 << pick_idx;
                        gnt_valid_q <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        state_q     <= IDLE;
                        gnt_idx_q   <= '0;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state_q     <= GAP;
                        gnt_idx_q   <= '0;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        last_q      <= gnt_idx_q;
                        // Only the hold limit raises timeout; done and withdraw win over it.
                        timeout_q   <= !done && req[gnt_idx_q];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_idx_q   <= '0;
                    gnt_q       <= '0;
                    gnt_valid_q <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign gnt_idx   = gnt_idx_q;
    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
